system_bridge_mc: RTL and testbench

//  Multi-slave memory-mapped I/O bridge between the CPU data port and up to NUM_SLAVES

---
 rtl/system_bridge_mc_if.sv | 22 ++
 rtl/system_bridge_mc.sv | 160 ++++++++++++++++
 tb/tb_system_bridge_mc.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/system_bridge_mc_if.sv
// CPU-side data-port bundle of the memory-mapped I/O bridge.
// The master modport is the CPU view; the slave modport is the bridge view.
interface system_bridge_mc_if;
    logic        readEnable;
    logic        writeEnable;
    logic [31:0] address;
    logic [31:0] writeDataIn;
    logic [31:0] readData;
    logic        ready;
    logic        exception;
    logic [31:0] exceptionAddress;

    modport master (
        output readEnable, writeEnable, address, writeDataIn,
        input  readData, ready, exception, exceptionAddress
    );

    modport slave (
        input  readEnable, writeEnable, address, writeDataIn,
        output readData, ready, exception, exceptionAddress
    );
endinterface

// File: rtl/system_bridge_mc.sv
// Multi-slave MMIO bridge: window decode, registered request/ready handshake with
// variable-latency slaves, bus timeout, and one-cycle exception with faulting address.
module system_bridge_mc #(
    parameter int unsigned               NUM_SLAVES     = 4,
    parameter int unsigned               ADDR_BITS      = 16,
    parameter int unsigned               SLAVE_WORDS    = 3,
    parameter int unsigned               SLAVE_AW       = 2,
    parameter logic [16*NUM_SLAVES-1:0] SLAVE_BASES    = 64'h7F30_7F20_7F10_7F00,
    parameter int unsigned               TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    system_bridge_mc_if.slave          cpu,
    output logic [NUM_SLAVES-1:0]      slaveSel,
    output logic [NUM_SLAVES-1:0]      slaveWE,
    output logic [SLAVE_AW-1:0]        slaveAddr,
    output logic [31:0]                slaveWData,
    input  logic [NUM_SLAVES*32-1:0]   slaveRData,
    input  logic [NUM_SLAVES-1:0]      slaveReady
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  state, state_next;
    logic [NUM_SLAVES-1:0]   sel_oh;
    logic                    we_q;
    logic                    err_q;
    logic [31:0]             addr_q;
    logic [31:0]             read_data_q;
    logic [31:0]             exc_addr_q;
    logic [CNT_W-1:0]        cnt;

    logic                    req;
    logic                    dec_hit;
    logic [NUM_SLAVES-1:0]   dec_oh;
    logic [SLAVE_AW-1:0]     dec_off;
    logic                    dec_err;
    logic [ADDR_BITS:0]      a_ext;
    logic [ADDR_BITS:0]      base_x;
    logic [ADDR_BITS:0]      rel;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;
    logic                    cnt_last;

    assign req   = cpu.readEnable | cpu.writeEnable;
    assign a_ext = {1'b0, cpu.address[ADDR_BITS-1:0]};

    // One extra bit keeps base + window size from wrapping at the top of the space
    always_comb begin
        dec_hit = 1'b0;
        dec_oh  = '0;
        dec_off = '0;
        base_x  = '0;
        rel     = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            base_x = (ADDR_BITS+1)'(SLAVE_BASES[16*i +: 16]);
            rel    = a_ext - base_x;
            if (!dec_hit && (a_ext >= base_x) && (rel < (ADDR_BITS+1)'(4*SLAVE_WORDS))) begin
                dec_hit   = 1'b1;
                dec_oh[i] = 1'b1;
                dec_off   = SLAVE_AW'(rel >> 2);
            end
        end
    end

    assign dec_err = !dec_hit || (cpu.address[1:0] != 2'b00)
                     || (cpu.readEnable && cpu.writeEnable);

    always_comb begin
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_oh[i]) begin
                sel_rdata = sel_rdata | slaveRData[32*i +: 32];
            end
        end
    end

    assign sel_ready = |(slaveReady & sel_oh);
    assign cnt_last  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (req) state_next = dec_err ? S_RESP : S_ACCESS;
            S_ACCESS: if (sel_ready || cnt_last) state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_oh      <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            read_data_q <= '0;
            exc_addr_q  <= '0;
            cnt         <= '0;
            slaveAddr   <= '0;
            slaveWData  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (dec_err) begin
                            err_q      <= 1'b1;
                            exc_addr_q <= cpu.address;
                        end else begin
                            err_q      <= 1'b0;
                            sel_oh     <= dec_oh;
                            slaveAddr  <= dec_off;
                            we_q       <= cpu.writeEnable;
                            slaveWData <= cpu.writeDataIn;
                            addr_q     <= cpu.address;
                            cnt        <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    // A ready in the expiry cycle takes priority over the timeout
                    if (sel_ready) begin
                        err_q <= 1'b0;
                        if (!we_q) begin
                            read_data_q <= sel_rdata;
                        end
                    end else if (cnt_last) begin
                        err_q      <= 1'b1;
                        exc_addr_q <= addr_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign slaveSel             = (state == S_ACCESS) ? sel_oh : '0;
    assign slaveWE              = we_q ? slaveSel : '0;
    assign cpu.ready            = (state == S_RESP);
    assign cpu.exception        = (state == S_RESP) && err_q;
    assign cpu.readData         = read_data_q;
    assign cpu.exceptionAddress = exc_addr_q;

endmodule

// File: tb/tb_system_bridge_mc.sv
// Bench for system_bridge_mc: transaction-level model predicts every output each cycle,
// driven by directed scenarios followed by randomized accesses.
module tb_system_bridge_mc;
    localparam int unsigned NS  = 4;
    localparam int unsigned SW  = 3;
    localparam int unsigned SAW = 2;
    localparam int unsigned TMO = 16;
    localparam logic [63:0] BASES = 64'h7F30_7F20_7F10_7F00;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NS-1:0]     slaveSel, slaveWE, slaveReady;
    logic [SAW-1:0]    slaveAddr;
    logic [31:0]       slaveWData;
    logic [NS*32-1:0]  slaveRData;

    system_bridge_mc_if cpu();

    system_bridge_mc #(
        .NUM_SLAVES(NS), .ADDR_BITS(16), .SLAVE_WORDS(SW), .SLAVE_AW(SAW),
        .SLAVE_BASES(BASES), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .cpu(cpu),
        .slaveSel(slaveSel), .slaveWE(slaveWE), .slaveAddr(slaveAddr),
        .slaveWData(slaveWData), .slaveRData(slaveRData), .slaveReady(slaveReady)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected outputs for the current cycle
    logic           chk_en = 1'b0;
    logic [NS-1:0]  e_sel = '0, e_we = '0;
    logic [SAW-1:0] e_saddr = '0;
    logic [31:0]    e_wdata = '0, e_rdata = '0, e_exca = '0;
    logic           e_ready = 1'b0, e_exc = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(cpu.ready), 32'(e_ready));
            check("exception", 32'(cpu.exception), 32'(e_exc));
            check("slaveSel", 32'(slaveSel), 32'(e_sel));
            check("slaveWE", 32'(slaveWE), 32'(e_we));
            check("readData", cpu.readData, e_rdata);
            check("exceptionAddress", cpu.exceptionAddress, e_exca);
            if (e_sel != '0) begin
                check("slaveAddr", 32'(slaveAddr), 32'(e_saddr));
                check("slaveWData", slaveWData, e_wdata);
            end
        end
    end

    // Window lookup: first slave whose byte range contains the low 16 address bits
    function automatic int decode(input logic [31:0] addr, output int unsigned off);
        int unsigned a;
        int unsigned b;
        a = addr[15:0];
        for (int i = 0; i < NS; i++) begin
            b = BASES[16*i +: 16];
            if (a >= b && a < b + 4*SW) begin
                off = (a - b) / 4;
                return i;
            end
        end
        off = 0;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        slaveReady = NS'($urandom);
        for (int i = 0; i < NS; i++) slaveRData[32*i +: 32] = $urandom;
    endtask

    task automatic idle(input int k);
        cpu.readEnable  = 1'b0;
        cpu.writeEnable = 1'b0;
        cpu.address     = $urandom;
        cpu.writeDataIn = $urandom;
        e_sel = '0; e_we = '0; e_ready = 1'b0; e_exc = 1'b0;
        repeat (k) step();
    endtask

    // Called just after a clock edge with the bridge idle; returns in the following idle cycle
    task automatic txn(input logic [31:0] addr, input bit re, input bit we,
                       input logic [31:0] wd, input int unsigned lat, input logic [31:0] rd);
        int          t;
        int unsigned off;
        bit          err, tmo;
        int unsigned n;
        logic [NS-1:0] oh;
        t   = decode(addr, off);
        err = (t < 0) || (addr[1:0] != 2'b00) || (re && we);
        oh  = (t >= 0) ? (NS'(1) << t) : '0;
        cpu.readEnable  = re;
        cpu.writeEnable = we;
        cpu.address     = addr;
        cpu.writeDataIn = wd;
        e_sel = '0; e_we = '0; e_ready = 1'b0; e_exc = 1'b0;
        if (err) begin
            step();
            e_ready = 1'b1; e_exc = 1'b1; e_exca = addr;
        end else begin
            tmo = (lat > TMO - 1);
            n   = tmo ? TMO : lat + 1;
            for (int unsigned c = 1; c <= n; c++) begin
                step();
                slaveReady = (slaveReady & ~oh) | ((c - 1 == lat) ? oh : '0);
                slaveRData[32*t +: 32] = rd;
                e_sel   = oh;
                e_we    = we ? oh : '0;
                e_saddr = SAW'(off);
                e_wdata = wd;
            end
            step();
            e_sel = '0; e_we = '0; e_ready = 1'b1; e_exc = tmo;
            if (tmo) e_exca = addr;
            else if (re) e_rdata = rd;
        end
        step();
        e_ready = 1'b0; e_exc = 1'b0;
    endtask

    initial begin
        int          idx;
        int unsigned off;
        logic [31:0] a;
        bit          re, we;
        int unsigned lat;
        int unsigned s, w, r;

        cpu.readEnable = 1'b0; cpu.writeEnable = 1'b0;
        cpu.address = '0; cpu.writeDataIn = '0;
        slaveReady = '0; slaveRData = '0;
        step(); step();
        check("reset_ready", 32'(cpu.ready), 32'h0);
        check("reset_sel", 32'(slaveSel), 32'h0);
        check("reset_rdata", cpu.readData, 32'h0);
        check("reset_exca", cpu.exceptionAddress, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Model decode pinned by hand
        idx = decode(32'h0000_7F04, off);
        check("model_dec_7F04_idx", 32'(idx), 32'd0);
        check("model_dec_7F04_off", off, 32'd1);
        idx = decode(32'h1234_7F28, off);
        check("model_dec_7F28_idx", 32'(idx), 32'd2);
        check("model_dec_7F28_off", off, 32'd2);
        idx = decode(32'h0000_7F0C, off);
        check("model_dec_gap", 32'(idx), 32'hFFFF_FFFF);

        txn(32'h0000_7F04, 1, 0, 32'h0, 0, 32'hDEAD_BEEF);
        check("t1_rdata", cpu.readData, 32'hDEAD_BEEF);
        txn(32'h1234_7F28, 0, 1, 32'h1234_5678, 3, 32'h0BAD_0BAD);
        check("t2_rdata_kept", cpu.readData, 32'hDEAD_BEEF);
        txn(32'h0000_7F0C, 1, 0, 32'h0, 0, 32'h0);
        check("t3_exca_gap", cpu.exceptionAddress, 32'h0000_7F0C);
        txn(32'h0000_7F02, 0, 1, 32'h5555_AAAA, 0, 32'h0);
        check("t3_exca_misal", cpu.exceptionAddress, 32'h0000_7F02);
        txn(32'h0000_7F14, 1, 0, 32'h0, 100, 32'h1111_2222);
        check("t4_exca_tmo", cpu.exceptionAddress, 32'h0000_7F14);
        check("t4_rdata_kept", cpu.readData, 32'hDEAD_BEEF);
        txn(32'h0000_7F14, 1, 0, 32'h0, TMO - 1, 32'hCAFE_0001);
        check("t4_last_cycle", cpu.readData, 32'hCAFE_0001);
        txn(32'h0000_7F00, 1, 1, 32'h0, 0, 32'h0);
        check("t6_rdata_kept", cpu.readData, 32'hCAFE_0001);
        check("t6_exca", cpu.exceptionAddress, 32'h0000_7F00);
        idle(1);

        // Asynchronous reset while the access is waiting on its slave
        chk_en = 1'b0;
        cpu.readEnable = 1'b1; cpu.address = 32'h0000_7F14;
        step(); step();
        slaveReady = '0;
        check("t5_sel_before", 32'(slaveSel), 32'h2);
        #2 reset = 1'b0;
        #1;
        check("t5_sel", 32'(slaveSel), 32'h0);
        check("t5_ready", 32'(cpu.ready), 32'h0);
        check("t5_rdata", cpu.readData, 32'h0);
        check("t5_exca", cpu.exceptionAddress, 32'h0);
        cpu.readEnable = 1'b0;
        step(); step();
        reset = 1'b1;
        e_rdata = '0; e_exca = '0;
        chk_en = 1'b1;
        idle(1);
        txn(32'h0000_7F30, 1, 0, 32'h0, 2, 32'hA5A5_5A5A);
        check("t5_after", cpu.readData, 32'hA5A5_5A5A);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            s = $urandom_range(0, NS - 1);
            w = $urandom_range(0, SW);
            a = {16'($urandom), 16'(BASES[16*s +: 16] + 16'(4*w))};
            r = $urandom_range(0, 9);
            if (r == 0) a[1:0] = 2'($urandom);
            else if (r == 1) a = $urandom;
            r  = $urandom_range(0, 9);
            re = (r == 0) || (r < 5);
            we = (r == 0) || (r >= 5);
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
            txn(a, re, we, $urandom, lat, $urandom);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
